// File: rtl/note_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | note_decoder                                                               |
// | Measures the half-period of an incoming square wave and classifies it to   |
// | a 3-bit note code (A=0 .. G=6, none=7). Optional macro: NOTE_DEGLITCH_EN.  |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module note_decoder #(
  parameter int CLK_HZ       = 50000000,
  parameter int A_HZ         = 220,
  parameter int B_HZ         = 247,
  parameter int C_HZ         = 261,
  parameter int D_HZ         = 294,
  parameter int E_HZ         = 330,
  parameter int F_HZ         = 349,
  parameter int G_HZ         = 392,
  parameter int TOL_SHIFT    = 6,
  parameter int STABLE_COUNT = 4,
  parameter int TIMEOUT_CYC  = 250000,
  parameter int CNT_W        = 20,
  parameter int MIN_HALF     = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wave_in,
  output logic [2:0]       note,
  output logic             note_valid,
  output logic             note_change,
  output logic [CNT_W-1:0] half_period
);

  localparam int SC_W = $clog2(STABLE_COUNT + 1);
  localparam logic [2:0]       NOTE_NONE  = 3'd7;
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_V  = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] MIN_HALF_V = CNT_W'(MIN_HALF);
  localparam logic [SC_W-1:0]  STABLE_V   = SC_W'(STABLE_COUNT);
  localparam logic [CNT_W-1:0] NOTE_N [7] = '{
    CNT_W'(CLK_HZ / A_HZ / 2), CNT_W'(CLK_HZ / B_HZ / 2), CNT_W'(CLK_HZ / C_HZ / 2),
    CNT_W'(CLK_HZ / D_HZ / 2), CNT_W'(CLK_HZ / E_HZ / 2), CNT_W'(CLK_HZ / F_HZ / 2),
    CNT_W'(CLK_HZ / G_HZ / 2)
  };

`ifdef NOTE_DEGLITCH_EN
  localparam bit DEGLITCH = 1'b1;
`else
  localparam bit DEGLITCH = 1'b0;
`endif

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_MEASURE = 1'b1
  } state_t;

  state_t           state_q;
  logic             sync1_q, sync2_q, ref_q;
  logic [CNT_W-1:0] cnt_q;
  logic [SC_W-1:0]  stab_q, stab_d;
  logic [2:0]       cand_q, cand_d;
  logic [2:0]       note_q;
  logic             valid_q, change_q;
  logic [CNT_W-1:0] half_q;

  logic             edge_w, glitch_w, edge_acc_w, sat_w;
  logic [CNT_W-1:0] m_w;
  logic [2:0]       class_w;

  function automatic logic [CNT_W-1:0] abs_diff(input logic [CNT_W-1:0] a,
                                                input logic [CNT_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  assign edge_w     = sync2_q ^ ref_q;
  assign sat_w      = (cnt_q == CNT_MAX);
  assign m_w        = sat_w ? CNT_MAX : (cnt_q + CNT_W'(1));
  // Start edges in IDLE are never treated as glitches.
  assign glitch_w   = DEGLITCH && (state_q == S_MEASURE) && (m_w < MIN_HALF_V);
  assign edge_acc_w = edge_w && !glitch_w;

  // Lowest-indexed matching note wins; a saturated count matches nothing.
  always_comb begin
    class_w = NOTE_NONE;
    if (!sat_w) begin
      for (int i = 6; i >= 0; i--) begin
        if (abs_diff(m_w, NOTE_N[i]) <= (NOTE_N[i] >> TOL_SHIFT)) begin
          class_w = 3'(i);
        end
      end
    end
  end

  always_comb begin
    cand_d = class_w;
    stab_d = SC_W'(1);
    if (class_w == cand_q) begin
      stab_d = (stab_q == STABLE_V) ? stab_q : (stab_q + SC_W'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      ref_q    <= 1'b0;
      cnt_q    <= '0;
      stab_q   <= '0;
      cand_q   <= NOTE_NONE;
      note_q   <= NOTE_NONE;
      valid_q  <= 1'b0;
      change_q <= 1'b0;
      half_q   <= '0;
    end else begin
      sync1_q  <= wave_in;
      sync2_q  <= sync1_q;
      ref_q    <= sync2_q;
      change_q <= 1'b0;

      if (edge_acc_w) begin
        cnt_q <= '0;
      end else if (!sat_w) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end

      if (state_q == S_IDLE) begin
        if (edge_acc_w) begin
          state_q <= S_MEASURE;
        end
      end else begin
        if (edge_acc_w) begin
          half_q <= m_w;
          cand_q <= cand_d;
          stab_q <= stab_d;
          if ((stab_d == STABLE_V) && (cand_d != note_q)) begin
            note_q   <= cand_d;
            valid_q  <= (cand_d != NOTE_NONE);
            change_q <= 1'b1;
          end
        end else if (cnt_q >= TIMEOUT_V) begin
          state_q  <= S_IDLE;
          stab_q   <= '0;
          note_q   <= NOTE_NONE;
          valid_q  <= 1'b0;
          change_q <= (note_q != NOTE_NONE);
        end
      end
    end
  end

  assign note        = note_q;
  assign note_valid  = valid_q;
  assign note_change = change_q;
  assign half_period = half_q;

endmodule
`default_nettype wire

// File: tb/tb_note_decoder.sv
`default_nettype none
// Testbench for note_decoder: directed scenarios plus randomized half-periods
// checked against a note-level reference model. Honours NOTE_DEGLITCH_EN.
module tb_note_decoder;

  localparam int CLK_HZ       = 250000;
  localparam int TOL_SHIFT    = 6;
  localparam int STABLE_COUNT = 4;
  localparam int TIMEOUT_CYC  = 1500;
  localparam int CNT_W        = 20;
  localparam int MIN_HALF     = 300;
  localparam int FREQ [7]     = '{220, 247, 261, 294, 330, 349, 392};

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             wave_in = 1'b0;
  logic [2:0]       note;
  logic             note_valid;
  logic             note_change;
  logic [CNT_W-1:0] half_period;

  int n_tests = 0;
  int n_fail = 0;
  int pulses = 0;
  int exp_pulses = 0;

  // Reference model state, updated per wave_in transition.
  bit m_idle = 1'b1;
  int m_cand = 7;
  int m_cnt = 0;
  int m_note = 7;
  int m_half = 0;
  int m_gap = 0;

  note_decoder #(
    .CLK_HZ(CLK_HZ), .A_HZ(220), .B_HZ(247), .C_HZ(261), .D_HZ(294),
    .E_HZ(330), .F_HZ(349), .G_HZ(392), .TOL_SHIFT(TOL_SHIFT),
    .STABLE_COUNT(STABLE_COUNT), .TIMEOUT_CYC(TIMEOUT_CYC), .CNT_W(CNT_W),
    .MIN_HALF(MIN_HALF)
  ) dut (
    .clk(clk), .reset(reset), .wave_in(wave_in), .note(note),
    .note_valid(note_valid), .note_change(note_change), .half_period(half_period)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (note_change === 1'b1) pulses++;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int nom(input int x);
    return CLK_HZ / FREQ[x] / 2;
  endfunction

  function automatic int classify(input int m);
    for (int x = 0; x < 7; x++) begin
      int n;
      int d;
      n = nom(x);
      d = (m > n) ? (m - n) : (n - m);
      if (d <= (n >> TOL_SHIFT)) return x;
    end
    return 7;
  endfunction

  task automatic model_timeout();
    m_idle = 1'b1;
    m_cnt  = 0;
    if (m_note != 7) exp_pulses++;
    m_note = 7;
  endtask

  task automatic model_edge();
    int c;
    if (!m_idle && m_gap > TIMEOUT_CYC + 1) model_timeout();
    if (m_idle) begin
      m_idle = 1'b0;
    end else begin
      m_half = m_gap;
      c = classify(m_gap);
      if (c == m_cand) m_cnt = (m_cnt < STABLE_COUNT) ? m_cnt + 1 : m_cnt;
      else begin
        m_cand = c;
        m_cnt  = 1;
      end
      if (m_cnt == STABLE_COUNT && m_cand != m_note) begin
        m_note = m_cand;
        exp_pulses++;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    m_gap++;
  endtask

  // Toggle wave_in p cycles after the previous toggle, then settle to a sample point.
  task automatic run_half(input int p);
    while (m_gap < p) tick();
    #1 wave_in = ~wave_in;
    model_edge();
    m_gap = 0;
    repeat (3) tick();
    @(negedge clk);
    #1;
  endtask

  task automatic hold(input int n);
    while (m_gap < n) tick();
    @(negedge clk);
    #1;
    if (!m_idle && m_gap >= TIMEOUT_CYC + 4) model_timeout();
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    n_tests++; if (note !== 3'd7) begin n_fail++; $display("FAIL reset_note: got %0d expected 7", note); end
    n_tests++; if (note_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b expected 0", note_valid); end
    n_tests++; if (note_change !== 1'b0) begin n_fail++; $display("FAIL reset_change: got %0b expected 0", note_change); end
    n_tests++; if (half_period !== '0) begin n_fail++; $display("FAIL reset_half: got %0d expected 0", half_period); end
    reset = 1'b0;
    m_gap = 0;
  endtask

  task automatic test_lock_a();
    for (int i = 0; i < 4; i++) run_half(nom(0));
    n_tests++; if (note !== 3'd7) begin n_fail++; $display("FAIL lock_a_early: got %0d expected 7", note); end
    run_half(nom(0));
    n_tests++; if (note !== 3'd0 || note_valid !== 1'b1) begin n_fail++; $display("FAIL lock_a_note: got %0d/%0b expected 0/1", note, note_valid); end
    n_tests++; if (half_period !== nom(0)) begin n_fail++; $display("FAIL lock_a_half: got %0d expected %0d", half_period, nom(0)); end
    n_tests++; if (pulses !== 1) begin n_fail++; $display("FAIL lock_a_pulses: got %0d expected 1", pulses); end
  endtask

  task automatic test_switch_g();
    for (int i = 0; i < 3; i++) run_half(nom(6));
    n_tests++; if (note !== 3'd0) begin n_fail++; $display("FAIL switch_g_hold: got %0d expected 0", note); end
    while (m_gap < nom(6)) tick();
    #1 wave_in = ~wave_in;
    model_edge();
    m_gap = 0;
    repeat (2) tick();
    @(negedge clk);
    #1;
    n_tests++; if (note !== 3'd0) begin n_fail++; $display("FAIL switch_g_pre: got %0d expected 0", note); end
    tick();
    @(negedge clk);
    #1;
    n_tests++; if (note !== 3'd6 || note_change !== 1'b1) begin n_fail++; $display("FAIL switch_g_update: got %0d/%0b expected 6/1", note, note_change); end
    n_tests++; if (half_period !== nom(6) || pulses !== 2) begin n_fail++; $display("FAIL switch_g_half_pulses: got %0d/%0d expected %0d/2", half_period, pulses, nom(6)); end
  endtask

  task automatic test_between();
    for (int i = 0; i < 4; i++) run_half(400);
    n_tests++; if (note !== 3'd7 || note_valid !== 1'b0) begin n_fail++; $display("FAIL between_note: got %0d/%0b expected 7/0", note, note_valid); end
    n_tests++; if (half_period !== 400 || pulses !== 3) begin n_fail++; $display("FAIL between_half_pulses: got %0d/%0d expected 400/3", half_period, pulses); end
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 5; i++) run_half(nom(4));
    n_tests++; if (note !== 3'd4 || pulses !== 4) begin n_fail++; $display("FAIL timeout_lock_e: got %0d/%0d expected 4/4", note, pulses); end
    hold(TIMEOUT_CYC + 20);
    n_tests++; if (note !== 3'd7 || note_valid !== 1'b0 || pulses !== 5) begin n_fail++; $display("FAIL timeout_silence: got %0d/%0b/%0d expected 7/0/5", note, note_valid, pulses); end
    run_half(nom(4));
    n_tests++; if (half_period !== nom(4) || note !== 3'd7) begin n_fail++; $display("FAIL timeout_start_only: got %0d/%0d expected %0d/7", half_period, note, nom(4)); end
    for (int i = 0; i < 4; i++) run_half(nom(4));
    n_tests++; if (note !== 3'd4 || pulses !== 6) begin n_fail++; $display("FAIL timeout_relock: got %0d/%0d expected 4/6", note, pulses); end
    run_half(TIMEOUT_CYC + 1);
    n_tests++; if (half_period !== TIMEOUT_CYC + 1 || note !== 3'd4) begin n_fail++; $display("FAIL timeout_simultaneous: got %0d/%0d expected %0d/4", half_period, note, TIMEOUT_CYC + 1); end
    run_half(TIMEOUT_CYC + 10);
    n_tests++; if (half_period !== TIMEOUT_CYC + 1 || note !== 3'd7 || pulses !== 7) begin n_fail++; $display("FAIL timeout_expired: got %0d/%0d/%0d expected %0d/7/7", half_period, note, pulses, TIMEOUT_CYC + 1); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) run_half(nom(2));
    if (wave_in) run_half(nom(2));
    n_tests++; if (note !== 3'd2 || pulses !== 8) begin n_fail++; $display("FAIL reset_mid_lock_c: got %0d/%0d expected 2/8", note, pulses); end
    while (m_gap < nom(2) / 2) tick();
    #1 reset = 1'b1;
    tick();
    #1 reset = 1'b0;
    @(negedge clk);
    #1;
    m_idle = 1'b1; m_cnt = 0; m_cand = 7; m_note = 7; m_half = 0;
    n_tests++; if (note !== 3'd7 || note_valid !== 1'b0 || note_change !== 1'b0 || half_period !== '0) begin
      n_fail++; $display("FAIL reset_mid_values: got %0d/%0b/%0b/%0d expected 7/0/0/0", note, note_valid, note_change, half_period);
    end
    for (int i = 0; i < 4; i++) run_half(nom(2));
    n_tests++; if (note !== 3'd7) begin n_fail++; $display("FAIL reset_mid_early: got %0d expected 7", note); end
    run_half(nom(2));
    n_tests++; if (note !== 3'd2 || pulses !== 9) begin n_fail++; $display("FAIL reset_mid_relock: got %0d/%0d expected 2/9", note, pulses); end
  endtask

`ifdef NOTE_DEGLITCH_EN
  task automatic test_deglitch();
    while (m_gap < 100) tick();
    #1 wave_in = ~wave_in;
    repeat (10) tick();
    #1 wave_in = ~wave_in;
    repeat (5) tick();
    @(negedge clk);
    #1;
    n_tests++; if (half_period !== nom(2) || note !== 3'd2) begin n_fail++; $display("FAIL deglitch_ignored: got %0d/%0d expected %0d/2", half_period, note, nom(2)); end
    run_half(nom(2) + 5);
    n_tests++; if (half_period !== nom(2) + 5 || note !== 3'd2 || pulses !== exp_pulses) begin
      n_fail++; $display("FAIL deglitch_next: got %0d/%0d/%0d expected %0d/2/%0d", half_period, note, pulses, nom(2) + 5, exp_pulses);
    end
  endtask
`endif

  task automatic test_random();
    int p;
    int len;
    int x;
    int tol;
    for (int r = 0; r < 24; r++) begin
      if ($urandom_range(0, 3) == 3) begin
        p = int'($urandom_range(300, 700));
      end else begin
        x   = int'($urandom_range(0, 6));
        tol = nom(x) >> TOL_SHIFT;
        case ($urandom_range(0, 4))
          0: p = nom(x) - tol - 1;
          1: p = nom(x) - tol;
          2: p = nom(x);
          3: p = nom(x) + tol;
          default: p = nom(x) + tol + 1;
        endcase
      end
      len = int'($urandom_range(1, 6));
      for (int j = 0; j < len; j++) begin
        run_half(p);
        n_tests++; if (note !== m_note[2:0] || note_valid !== (m_note != 7)) begin
          n_fail++; $display("FAIL random_note: p=%0d got %0d/%0b expected %0d/%0b", p, note, note_valid, m_note, m_note != 7);
        end
        n_tests++; if (half_period !== m_half || pulses !== exp_pulses) begin
          n_fail++; $display("FAIL random_half_pulses: p=%0d got %0d/%0d expected %0d/%0d", p, half_period, pulses, m_half, exp_pulses);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_lock_a();
    test_switch_g();
    test_between();
    test_timeout();
    test_reset_mid();
`ifdef NOTE_DEGLITCH_EN
    test_deglitch();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
